// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] opa, opb, hi, lo, res_q;
    logic            done_q;

    logic            a_sgn, b_sgn, neg_a, neg_b, dz, fast_go;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum, shifted;
    logic            ge;
    logic [XLEN-1:0] nhi, nlo, quo, remv, final_res;
    logic [2*XLEN-1:0] prod_s;

    function automatic logic [XLEN-1:0] pick(input logic [2:0] f, input logic [2*XLEN-1:0] p,
                                             input logic [XLEN-1:0] q, input logic [XLEN-1:0] r);
        case (f)
            3'b000:                pick = p[XLEN-1:0];
            3'b001, 3'b010, 3'b011: pick = p[2*XLEN-1:XLEN];
            3'b100, 3'b101:        pick = q;
            default:               pick = r;
        endcase
    endfunction

    // MULHSU treats only rs1 as signed; unsigned ops keep both flags clear
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'b010:  a_sgn = 1'b1;
            default: ;
        endcase
    end

    assign neg_a = a_sgn & src_a[XLEN-1];
    assign neg_b = b_sgn & src_b[XLEN-1];
    assign mag_a = neg_a ? -src_a : src_a;
    assign mag_b = neg_b ? -src_b : src_b;
    assign dz    = funct3[2] & (src_b == '0);

    // One iteration: hi/lo hold {partial product} for multiply, {remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum = {1'b0, hi} + ({1'b0, opa} & {(XLEN+1){lo[0]}});
        shifted = {hi, lo[XLEN-1]};
        ge      = shifted >= {1'b0, opb};
        if (op[2]) begin
            nhi = ge ? (shifted[XLEN-1:0] - opb) : shifted[XLEN-1:0];
            nlo = {lo[XLEN-2:0], ge};
        end else begin
            nhi = mul_sum[XLEN:1];
            nlo = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    assign prod_s    = (sign_a ^ sign_b) ? -{nhi, nlo} : {nhi, nlo};
    assign quo       = (sign_a ^ sign_b) ? -nlo : nlo;
    assign remv      = sign_a ? -nhi : nhi;
    assign final_res = pick(op, prod_s, quo, remv);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fprod, fprod_s;
    logic [XLEN-1:0]   fast_res;
    assign fprod    = {{XLEN{1'b0}}, opa} * {{XLEN{1'b0}}, opb};
    assign fprod_s  = (sign_a ^ sign_b) ? -fprod : fprod;
    assign fast_res = pick(op, fprod_s, '0, '0);
    assign fast_go  = ~funct3[2];
    // Fast multiply is presented straight from the latched operands during DONE
    assign result   = ((state == DONE) && !op[2]) ? fast_res : res_q;
`else
    assign fast_go  = 1'b0;
    assign result   = res_q;
`endif

    assign stall = reset_n & ((start & ~flush & (state == IDLE)) | (state == CALC));
    assign busy  = (state != IDLE);
    assign done  = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            hi     <= '0;
            lo     <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        op     <= funct3;
                        sign_a <= neg_a;
                        sign_b <= neg_b;
                        opa    <= mag_a;
                        opb    <= mag_b;
                        hi     <= '0;
                        lo     <= funct3[2] ? mag_a : mag_b;
                        cnt    <= '0;
                        if (dz) begin
                            res_q  <= funct3[1] ? src_a : '1;
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else if (fast_go) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        hi <= nhi;
                        lo <= nlo;
                        if (cnt == CW'(XLEN-1)) begin
                            res_q  <= final_res;
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DONE: begin
`ifdef MULDIV_FAST_MUL_EN
                        if (!op[2]) res_q <= fast_res;
`endif
                        cnt   <= '0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: random and directed M-extension ops vs. arithmetic model.
module tb_muldiv_sequencer;
    localparam int XLEN = 32;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        stall, busy, done;
    logic [31:0] result;

    int checks = 0, failures = 0, cyc = 0;
    logic [31:0] last_res = '0;

    typedef struct {
        logic [31:0] res;
        int          at;
        logic [2:0]  f;
    } exp_t;
    exp_t sbq[$];

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Waits for IDLE (throwing ignored junk starts at the busy unit), then issues one op
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit track);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            start  = 1'($urandom_range(0, 1));
            funct3 = 3'($urandom);
            src_a  = $urandom;
            src_b  = $urandom;
            n++;
            @(negedge clk);
        end
        if (busy) chk("idle_timeout", busy, 0);
        start = 1'b1; funct3 = f; src_a = a; src_b = b;
        if (track) sbq.push_back('{model(f, a, b), cyc + latency(f, b), f});
        #1 chk("stall_accept", stall, 1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done: got result %0h expected no done (cycle %0d)", result, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk($sformatf("result_op%0d", e.f), result, e.res);
                chk($sformatf("latency_op%0d", e.f), cyc, e.at);
                chk("stall_in_done", stall, 0);
                last_res = e.res;
            end
        end
    end

    logic [2:0]  df [12] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd1, 3'd3, 3'd0, 3'd2, 3'd4, 3'd6};
    logic [31:0] da [12] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF9};
    logic [31:0] db [12] = '{32'd3, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003, 32'd0, 32'd0};

    initial begin
        start = 1'b1;
        #2;
        chk("reset_result", result, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_stall", stall, 0);
        repeat (2) @(negedge clk);
        start = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) issue(df[i], da[i], db[i], 1);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 100); b = $urandom_range(1, 9); end
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            issue(3'($urandom), a, b, 1);
        end

        // flush mid-divide: accept at cycle c, flush during c+10, idle at c+11, new op at c+12
        issue(3'd4, 32'h1234_5678, 32'd7, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_stall", stall, 0);
        chk("flush_done", done, 0);
        chk("flush_result", result, last_res);
        issue(3'd5, 32'd100, 32'd7, 1);

        // start and flush together must not accept
        issue(3'd7, 32'd9, 32'd4, 1);
        while (busy) @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd4; src_a = 32'd50; src_b = 32'd5;
        #1 chk("startflush_stall", stall, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("startflush_busy", busy, 0);

        // reset in the middle of MULHU
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        start = 1'b1;
        #1;
        chk("midreset_result", result, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_stall", stall, 0);
        @(negedge clk);
        start = 1'b0;
        reset_n = 1'b1;
        last_res = '0;
        repeat (40) @(negedge clk);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_result", result, 0);

        issue(3'd6, 32'hFFFF_FFEC, 32'd3, 1);
        for (int n = 0; n < 100 && (busy || sbq.size() != 0); n++) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
